inst_rom_arbiter: RTL and testbench

//  Shares the single-port, combinational-read instruction ROM between two requesters.
//  M0 is the IF stage fetch port. M1 is the secondary port (MEM-stage constant load / debug read).

---
 rtl/inst_rom_arbiter.sv | 120 ++++++++++++
 tb/tb_inst_rom_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter in front of a combinational-read instruction ROM; responses arrive one cycle after grant.
// Build option ROM_ARB_RR_EN: round-robin conflict resolution instead of fixed priority with starvation guard.
module inst_rom_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int ROM_DEPTH    = 2048,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);
    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(ROM_DEPTH);

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    logic              bad0, bad1, win1;
    logic              rvalid0_q, rvalid0_d, err0_q, err0_d;
    logic              rvalid1_q, rvalid1_d, err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              last_owner_q, last_owner_d;
`ifndef ROM_ARB_RR_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0]  starve_q, starve_d;
`endif

    assign bad0 = addr_bad(addr0);
    assign bad1 = addr_bad(addr1);

    // Conflict winner: M1 only when it has been starved (fixed) or M0 owned the ROM last (round-robin).
`ifdef ROM_ARB_RR_EN
    assign win1 = !last_owner_q;
`else
    assign win1 = (starve_q == LIMIT);
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                gnt0 = !win1;
                gnt1 = win1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        rom_ce   = (gnt0 && !bad0) || (gnt1 && !bad1);
        rom_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);
    end

    always_comb begin
        rvalid0_d    = gnt0;
        err0_d       = gnt0 && bad0;
        rdata0_d     = gnt0 ? (bad0 ? '0 : rom_inst) : rdata0_q;
        rvalid1_d    = gnt1;
        err1_d       = gnt1 && bad1;
        rdata1_d     = gnt1 ? (bad1 ? '0 : rom_inst) : rdata1_q;
        last_owner_d = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_owner_q);
`ifndef ROM_ARB_RR_EN
        starve_d = '0;
        if (req1 && !gnt1) begin
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 1'b1;
        end
`endif
    end

    // A pending response is discarded when reset lands on its capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_q    <= 1'b0;
            err0_q       <= 1'b0;
            rdata0_q     <= '0;
            rvalid1_q    <= 1'b0;
            err1_q       <= 1'b0;
            rdata1_q     <= '0;
            last_owner_q <= 1'b1;
`ifndef ROM_ARB_RR_EN
            starve_q     <= '0;
`endif
        end else begin
            rvalid0_q    <= rvalid0_d;
            err0_q       <= err0_d;
            rdata0_q     <= rdata0_d;
            rvalid1_q    <= rvalid1_d;
            err1_q       <= err1_d;
            rdata1_q     <= rdata1_d;
            last_owner_q <= last_owner_d;
`ifndef ROM_ARB_RR_EN
            starve_q     <= starve_d;
`endif
        end
    end

    assign rvalid0 = rvalid0_q;
    assign err0    = err0_q;
    assign rdata0  = rdata0_q;
    assign rvalid1 = rvalid1_q;
    assign err1    = err1_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: directed vector table, hand-written multi-cycle sequences, random run vs reference model.
`timescale 1ns/1ps
module tb_inst_rom_arbiter;
    localparam int AW = 32, DW = 32, DEPTH = 2048, SLIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1, rom_ce;
    logic [DW-1:0] rdata0, rdata1, rom_inst;
    logic [AW-1:0] rom_addr;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    // ROM image: word i holds 0x1000_0000 + i
    assign rom_inst = 32'h1000_0000 + (rom_addr >> 2);

    inst_rom_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(DEPTH), .STARVE_LIMIT(SLIM), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
    );

    typedef struct {
        logic        rst, r0;
        logic [31:0] a0;
        logic        r1;
        logic [31:0] a1;
        logic        g0, g1, ce;
        logic [31:0] ra;
        logic        v0, e0;
        logic [31:0] d0;
        logic        v1, e1;
        logic [31:0] d1;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic g0, input logic g1, input logic ce,
                             input logic [31:0] ra, input logic v0, input logic e0, input logic [31:0] d0,
                             input logic v1, input logic e1, input logic [31:0] d1);
        chk({tag, " gnt0"}, gnt0, g0);
        chk({tag, " gnt1"}, gnt1, g1);
        chk({tag, " rom_ce"}, rom_ce, ce);
        chk({tag, " rom_addr"}, rom_addr, ra);
        chk({tag, " rvalid0"}, rvalid0, v0);
        chk({tag, " err0"}, err0, e0);
        chk({tag, " rdata0"}, rdata0, d0);
        chk({tag, " rvalid1"}, rvalid1, v1);
        chk({tag, " err1"}, err1, e1);
        chk({tag, " rdata1"}, rdata1, d1);
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) return 32'($urandom_range(0, DEPTH - 1)) * 4;
        if (k == 6) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        if (k == 7) return 32'($urandom_range(DEPTH, 100000)) * 4;
        if (k == 8) return 32'h1FFC;
        return 32'h2000;
    endfunction

    task automatic drive(input logic r, input logic q0, input logic [31:0] a0,
                         input logic q1, input logic [31:0] a1);
        @(posedge clk);
        #1;
        rst = r; req0 = q0; addr0 = a0; req1 = q1; addr1 = a1;
        #3;
    endtask

    // reference model state
    logic        m_v0, m_e0, m_v1, m_e1;
    logic [31:0] m_d0, m_d1;
    int          losses;
    bit          last_was1;

    initial begin
        bit w0, w1, p1, pany, exp1;
        logic [31:0] wa;

        tbl[0]  = '{1'b1, 1'b1, 32'h8,    1'b1, 32'hC,  1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 32'h8,    1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h8,    1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h8,    1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h8,    1'b1, 1'b0, 32'h1000_0002, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h8,    1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h8,    1'b1, 1'b0, 32'h1000_0002, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h6,  1'b0, 1'b1, 1'b0, 32'h6,    1'b1, 1'b0, 32'h1000_0002, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 32'h2000, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h1000_0002, 1'b1, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'hC,  1'b0, 1'b1, 1'b1, 32'hC,    1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 32'h10,   1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 32'h10,   1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1000_0003};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h1000_0004, 1'b0, 1'b0, 32'h1000_0003};
        tbl[10] = '{1'b0, 1'b1, 32'h1FFC, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h1FFC, 1'b0, 1'b0, 32'h1000_0004, 1'b0, 1'b0, 32'h1000_0003};
        tbl[11] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h1000_07FF, 1'b0, 1'b0, 32'h1000_0003};

        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1);
            check_all($sformatf("vec%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].ce, tbl[i].ra,
                      tbl[i].v0, tbl[i].e0, tbl[i].d0, tbl[i].v1, tbl[i].e1, tbl[i].d1);
        end

        // both ports held from reset: starvation guard (fixed) or alternation (round-robin)
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        p1 = 1'b0;
        pany = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b1, 32'hC);
`ifdef ROM_ARB_RR_EN
            exp1 = (c % 2 == 0);
`else
            exp1 = (c % 5 == 0);
`endif
            chk($sformatf("hold c%0d gnt1", c), gnt1, exp1);
            chk($sformatf("hold c%0d gnt0", c), gnt0, !exp1);
            chk($sformatf("hold c%0d rvalid1", c), rvalid1, pany && p1);
            chk($sformatf("hold c%0d rvalid0", c), rvalid0, pany && !p1);
            if (pany && p1) chk($sformatf("hold c%0d rdata1", c), rdata1, 32'h1000_0003);
            p1 = exp1;
            pany = 1'b1;
        end

        // reset on the capture edge of a grant drops the response; M0 wins the first conflict after
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
        chk("rstmid gnt0", gnt0, 1'b1);
        #3 rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rstmid rvalid0", rvalid0, 1'b0);
        chk("rstmid gnt0 in reset", gnt0, 1'b0);
        chk("rstmid rom_addr in reset", rom_addr, 32'h0);
        drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h24);
        chk("rstmid first gnt0", gnt0, 1'b1);
        chk("rstmid first gnt1", gnt1, 1'b0);
        chk("rstmid first rom_addr", rom_addr, 32'h20);

        // random run against the reference model
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        m_v0 = 0; m_e0 = 0; m_d0 = 0; m_v1 = 0; m_e1 = 0; m_d1 = 0;
        losses = 0;
        last_was1 = 1'b1;
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, rand_addr(),
                  $urandom_range(0, 2) != 0, rand_addr());
            w0 = 1'b0;
            w1 = 1'b0;
            if (!rst) begin
                if (req0 && req1) begin
`ifdef ROM_ARB_RR_EN
                    w1 = !last_was1;
`else
                    w1 = (losses >= SLIM);
`endif
                    w0 = !w1;
                end else begin
                    w0 = req0;
                    w1 = req1;
                end
            end
            wa = w0 ? addr0 : (w1 ? addr1 : 32'h0);
            check_all($sformatf("rnd%0d", n), w0, w1, (w0 || w1) && !is_bad(wa), wa,
                      m_v0, m_e0, m_d0, m_v1, m_e1, m_d1);
            if (rst) begin
                m_v0 = 0; m_e0 = 0; m_d0 = 0; m_v1 = 0; m_e1 = 0; m_d1 = 0;
                losses = 0;
                last_was1 = 1'b1;
            end else begin
                m_v0 = w0;
                m_e0 = w0 && is_bad(addr0);
                if (w0) m_d0 = is_bad(addr0) ? 32'h0 : 32'h1000_0000 + addr0 / 4;
                m_v1 = w1;
                m_e1 = w1 && is_bad(addr1);
                if (w1) m_d1 = is_bad(addr1) ? 32'h0 : 32'h1000_0000 + addr1 / 4;
                if (req1 && !w1) losses = (losses + 1 > SLIM) ? SLIM : losses + 1;
                else losses = 0;
                if (w0) last_was1 = 1'b0;
                if (w1) last_was1 = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
